// File: rtl/mem_loader.sv
// Stream-to-memory loader: consumes <start addr, count, data...> words on a
// valid/ready stream and emits one registered write strobe per data word.
module mem_loader #(
  parameter  int DEPTH  = 16,
  parameter  int WIDTH  = 8,
  localparam int AWIDTH = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  output logic              mem_wr_en,
  output logic [AWIDTH-1:0] mem_wr_addr,
  output logic [WIDTH-1:0]  mem_wr_data,
  output logic              load_busy,
  output logic              load_done,
  output logic              load_err
);

  typedef enum logic [1:0] {IDLE, CNT, DATA, DONE} state_t;

  state_t              state_q, state_d;
  logic [AWIDTH-1:0]   addr_q, addr_d;
  logic [AWIDTH-1:0]   rem_q, rem_d;
  logic                in_ready_q, in_ready_d;
  logic                wr_en_q, wr_en_d;
  logic [AWIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [WIDTH-1:0]    wr_data_q, wr_data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic                xfer;
  logic [WIDTH-1:0]    hdr_hi;

  assign xfer   = in_valid && in_ready_q;
  // Bits above the address field; a shift keeps this legal when WIDTH == AWIDTH.
  assign hdr_hi = in_data >> AWIDTH;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;
    case (state_q)
      IDLE: if (xfer) begin
        if (hdr_hi != '0) begin
          err_d = 1'b1;
        end else begin
          addr_d  = in_data[AWIDTH-1:0];
          err_d   = 1'b0;
          state_d = CNT;
        end
      end
      CNT: if (xfer) begin
        rem_d   = in_data[AWIDTH-1:0];
        busy_d  = 1'b1;
        state_d = DATA;
      end
      DATA: if (xfer) begin
        wr_en_d   = 1'b1;
        wr_addr_d = addr_q;
        wr_data_d = in_data;
        addr_d    = (addr_q == AWIDTH'(DEPTH-1)) ? '0 : addr_q + 1'b1;
        rem_d     = rem_q - 1'b1;
        if (rem_q == '0) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    // Ready is decoded from the next state so it is a pure flop output.
    in_ready_d = (state_d != DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      in_ready_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      in_ready_q <= in_ready_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign mem_wr_en   = wr_en_q;
  assign mem_wr_addr = wr_addr_q;
  assign mem_wr_data = wr_data_q;
  assign load_busy   = busy_q;
  assign load_done   = done_q;
  assign load_err    = err_q;

endmodule

// File: tb/tb_mem_loader.sv
// Scoreboard bench for mem_loader: the driver queues expected writes derived
// from (start + i) mod DEPTH; a negedge monitor pops and compares each strobe.
module tb_mem_loader;
  localparam int DEPTH = 16;
  localparam int WIDTH = 8;
  localparam int AW    = 4;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    int addr;
    int data;
    int done;
    int edge_i;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic            mem_wr_en;
  logic [AW-1:0]   mem_wr_addr;
  logic [WIDTH-1:0] mem_wr_data;
  logic            load_busy, load_done, load_err;

  mem_loader #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data), .load_busy(load_busy), .load_done(load_done),
    .load_err(load_err)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  always @(posedge clk) cyc++;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every strobe must match the oldest outstanding expected write.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mem_wr_en) begin
        if (q.size() == 0) begin
          chk("unexpected_write", int'(mem_wr_en), 0);
        end else begin
          e = q.pop_front();
          chk("wr_addr", int'(mem_wr_addr), e.addr);
          chk("wr_data", int'(mem_wr_data), e.data);
          chk("done_with_strobe", int'(load_done), e.done);
          chk("strobe_latency", cyc, e.edge_i);
          chk("busy_on_write", int'(load_busy), 1);
        end
      end else begin
        chk("stray_done", int'(load_done), 0);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the word transferred.
  task automatic send_word(input logic [7:0] w, input bit is_data,
                           input int ea, input int ed);
    int n = 0;
    in_valid = 1'b1;
    in_data  = w;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("ready_timeout", int'(in_ready), 1);
      in_valid = 1'b0;
      return;
    end
    if (is_data) q.push_back('{addr: ea, data: int'(w), done: ed, edge_i: cyc + 1});
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_load(input logic [7:0] start, input logic [7:0] cnt,
                         input bq_t d, input int gap);
    int n;
    send_word(start, 1'b0, 0, 0);
    chk("err_clear_on_hdr", int'(load_err), 0);
    send_word(cnt, 1'b0, 0, 0);
    chk("busy_after_cnt", int'(load_busy), 1);
    n = (int'(cnt) % DEPTH) + 1;
    for (int i = 0; i < n; i++) begin
      if (i > 0) repeat (gap) @(negedge clk);
      send_word(d[i], 1'b1, (int'(start) + i) % DEPTH, (i == n - 1) ? 1 : 0);
    end
    chk("ready_low_in_done", int'(in_ready), 0);
    chk("done_pulse", int'(load_done), 1);
    @(negedge clk);
    chk("busy_drop", int'(load_busy), 0);
    chk("ready_back", int'(in_ready), 1);
  endtask

  task automatic chk_reset_vals();
    chk("rst_ready", int'(in_ready), 0);
    chk("rst_wr_en", int'(mem_wr_en), 0);
    chk("rst_wr_addr", int'(mem_wr_addr), 0);
    chk("rst_wr_data", int'(mem_wr_data), 0);
    chk("rst_busy", int'(load_busy), 0);
    chk("rst_done", int'(load_done), 0);
    chk("rst_err", int'(load_err), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    bq_t d;
    logic [7:0] st, cn;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_vals();
    rst = 1'b0;

    // Basic load
    d = '{8'hA1, 8'hB2, 8'hC3};
    do_load(8'h03, 8'h02, d, 0);

    // Wrap-around past DEPTH-1
    d = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_load(8'h0E, 8'h03, d, 0);
    chk("wrap_no_err", int'(load_err), 0);

    // Stalls between data words
    d = '{8'hA1, 8'hB2, 8'hC3};
    do_load(8'h03, 8'h02, d, 2);

    // Bad header: discarded, sticky error, stays idle
    send_word(8'h23, 1'b0, 0, 0);
    chk("bad_hdr_err", int'(load_err), 1);
    chk("bad_hdr_ready", int'(in_ready), 1);
    chk("bad_hdr_busy", int'(load_busy), 0);
    @(negedge clk);
    chk("bad_hdr_err_sticky", int'(load_err), 1);
    d = '{8'h5A};
    do_load(8'h01, 8'h00, d, 0);

    // Full fill
    d = {};
    for (int i = 0; i < DEPTH; i++) d.push_back(8'(i));
    do_load(8'h00, 8'h0F, d, 0);

    // Randomized loads; count upper bits are random and must be ignored
    repeat (20) begin
      if ($urandom_range(0, 3) == 0) begin
        send_word({4'($urandom_range(1, 15)), 4'($urandom_range(0, 15))}, 1'b0, 0, 0);
        chk("rand_bad_hdr_err", int'(load_err), 1);
      end
      st = 8'($urandom_range(0, DEPTH - 1));
      cn = 8'($urandom_range(0, 255));
      d = {};
      for (int i = 0; i < DEPTH; i++) d.push_back(8'($urandom));
      do_load(st, cn, d, int'($urandom_range(0, 2)));
    end

    // Reset mid-load: the 0x12 transfer coincides with the reset edge
    send_word(8'h04, 1'b0, 0, 0);
    send_word(8'h05, 1'b0, 0, 0);
    send_word(8'h10, 1'b1, 4, 0);
    send_word(8'h11, 1'b1, 5, 0);
    in_valid = 1'b1;
    in_data  = 8'h12;
    rst      = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    chk_reset_vals();
    d = '{8'h77};
    do_load(8'h00, 8'h00, d, 0);

    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
